// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's 16-bit result stream into 128-bit words and queues them for the host write path.
// Define CNN_LAYER_ACCEL_PACKER_ZERO_PAD_EN to zero the unused lanes of a partial closing word.
module cnn_layer_accel_result_packer #(
  parameter int unsigned C_DATA_WIDTH = 16,
  parameter int unsigned C_LANES      = 8,
  parameter int unsigned C_FIFO_DEPTH = 4
) (
  input  logic                                clk_if,
  input  logic                                rst_n,
  input  logic                                result_valid,
  output logic                                result_accept,
  input  logic [C_DATA_WIDTH-1:0]             result_data,
  input  logic                                result_flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [C_DATA_WIDTH*C_LANES-1:0]     out_data,
  output logic [C_LANES-1:0]                  out_keep,
  output logic                                out_last,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned WordW    = C_DATA_WIDTH * C_LANES;
  localparam int unsigned LaneIdxW = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  localparam int unsigned PtrW     = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(C_FIFO_DEPTH + 1);

  localparam logic [LaneIdxW-1:0] LastLane  = LaneIdxW'(C_LANES - 1);
  localparam logic [CntW-1:0]     FullCount = CntW'(C_FIFO_DEPTH);

  typedef logic [C_LANES-1:0][C_DATA_WIDTH-1:0] lanes_t;

  // Accumulator state
  lanes_t                lane_q, lane_d;
  logic [LaneIdxW-1:0]   lane_idx_q, lane_idx_d;
  logic                  flush_pend_q, flush_pend_d;

  // Word FIFO state
  logic [WordW-1:0]      mem_data_q [C_FIFO_DEPTH];
  logic [C_LANES-1:0]    mem_keep_q [C_FIFO_DEPTH];
  logic                  mem_last_q [C_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  // Handshake and push controls
  logic                  fifo_full;
  logic                  beat;
  logic                  flush_req;
  logic                  close_word;
  logic                  pop;
  logic                  push;
  lanes_t                push_data;
  logic [C_LANES-1:0]    push_keep;
  logic                  push_last;

  always_comb begin
    fifo_full     = (count_q == FullCount);
    result_accept = rst_n && !flush_pend_q && !((lane_idx_q == LastLane) && fifo_full);
    beat          = result_valid && result_accept;
    // A flush arriving while one is already pending is dropped.
    flush_req     = result_flush && !flush_pend_q;
    // Pending flush closes only when there is room; beats are blocked meanwhile.
    close_word    = flush_pend_q && !fifo_full;
    out_valid     = (count_q != '0);
    pop           = out_valid && out_ready;
  end

  // Accumulator and flush sequencing
  always_comb begin
    lane_d       = lane_q;
    lane_idx_d   = lane_idx_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_data    = lane_q;
    push_keep    = '0;
    push_last    = 1'b0;

    if (beat) begin
      lane_d[lane_idx_q] = result_data;
      if (lane_idx_q == LastLane) begin
        // A flush coinciding with the final lane marks this word last; no closing word follows.
        push       = 1'b1;
        push_data  = lane_d;
        push_keep  = '1;
        push_last  = flush_req;
        lane_idx_d = '0;
      end else begin
        lane_idx_d   = lane_idx_q + 1'b1;
        flush_pend_d = flush_req;
      end
    end else if (close_word) begin
      push         = 1'b1;
      push_last    = 1'b1;
      lane_idx_d   = '0;
      flush_pend_d = 1'b0;
      for (int unsigned i = 0; i < C_LANES; i++) begin
        push_keep[i] = (LaneIdxW'(i) < lane_idx_q);
`ifdef CNN_LAYER_ACCEL_PACKER_ZERO_PAD_EN
        if (!push_keep[i]) begin
          push_data[i] = '0;
        end
`else
        // An empty closing word carries zero data even without padding.
        if (lane_idx_q == '0) begin
          push_data[i] = '0;
        end
`endif
      end
    end else if (flush_req) begin
      flush_pend_d = 1'b1;
    end
  end

  // FIFO pointer and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= '0;
      lane_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      lane_q       <= lane_d;
      lane_idx_q   <= lane_idx_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < C_FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_keep_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_keep_q[wr_ptr_q] <= push_keep;
      mem_last_q[wr_ptr_q] <= push_last;
    end
  end

  // Head of the FIFO is presented directly; idle outputs read as zero.
  always_comb begin
    out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
    out_keep   = out_valid ? mem_keep_q[rd_ptr_q] : '0;
    out_last   = out_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    fifo_count = count_q;
  end

`ifndef SYNTHESIS
  push_never_full_a : assert property (@(posedge clk_if) disable iff (!rst_n)
    !(push && fifo_full));

  stall_holds_word_a : assert property (@(posedge clk_if) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_keep)
                                   && $stable(out_last)));

  count_in_range_a : assert property (@(posedge clk_if) disable iff (!rst_n)
    count_q <= FullCount);
`endif

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Scoreboard bench for cnn_layer_accel_result_packer: a cycle model predicts handshakes and words.
module tb_cnn_layer_accel_result_packer;

  localparam int Depth = 4;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   keep;
    logic         last;
  } word_t;

  logic         clk_if = 1'b0;
  logic         rst_n;
  logic         result_valid;
  logic         result_accept;
  logic [15:0]  result_data;
  logic         result_flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_keep;
  logic         out_last;
  logic [2:0]   fifo_count;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  word_t             sb[$];
  word_t             exp_q[$];
  word_t             got_q[$];
  int                m_idx;
  logic              m_pend;
  logic [7:0][15:0]  m_lanes;

  // Last cycle's observed and predicted handshake values
  logic s_acc, s_acc_x, s_vld, s_vld_x;
  int   s_cnt, s_cnt_x;

  cnn_layer_accel_result_packer #(
    .C_DATA_WIDTH (16),
    .C_LANES      (8),
    .C_FIFO_DEPTH (Depth)
  ) dut (
    .clk_if        (clk_if),
    .rst_n         (rst_n),
    .result_valid  (result_valid),
    .result_accept (result_accept),
    .result_data   (result_data),
    .result_flush  (result_flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .fifo_count    (fifo_count)
  );

  always #5 clk_if = ~clk_if;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic model_reset();
    sb.delete();
    exp_q.delete();
    got_q.delete();
    m_idx   = 0;
    m_pend  = 1'b0;
    m_lanes = '0;
  endtask

  // Drive one cycle, sample the DUT before the edge, then advance the model across the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic fl, input logic rdy);
    word_t w;
    logic  beat, freq, full, pop;
    result_valid = v;
    result_data  = d;
    result_flush = fl;
    out_ready    = rdy;
    #1;
    s_acc = result_accept;
    s_vld = out_valid;
    s_cnt = int'(fifo_count);
    if (out_valid && rdy) begin
      w = {out_data, out_keep, out_last};
      got_q.push_back(w);
    end
    full    = (sb.size() == Depth);
    s_acc_x = !m_pend && !(m_idx == 7 && full);
    s_vld_x = (sb.size() != 0);
    s_cnt_x = sb.size();
    beat    = v && s_acc_x;
    freq    = fl && !m_pend;
    pop     = rdy && (sb.size() != 0);
    if (pop) exp_q.push_back(sb.pop_front());
    if (beat) begin
      m_lanes[m_idx] = d;
      if (m_idx == 7) begin
        w.data = m_lanes;
        w.keep = 8'hFF;
        w.last = freq;
        sb.push_back(w);
        m_idx = 0;
      end else begin
        m_idx++;
        if (freq) m_pend = 1'b1;
      end
    end else if (m_pend && !full) begin
      w.data = m_lanes;
      w.last = 1'b1;
      for (int i = 0; i < 8; i++) begin
        w.keep[i] = (i < m_idx);
`ifdef CNN_LAYER_ACCEL_PACKER_ZERO_PAD_EN
        if (!w.keep[i]) w.data[i*16 +: 16] = '0;
`else
        if (m_idx == 0) w.data[i*16 +: 16] = '0;
`endif
      end
      sb.push_back(w);
      m_idx  = 0;
      m_pend = 1'b0;
    end else if (freq) begin
      m_pend = 1'b1;
    end
    @(posedge clk_if);
    @(negedge clk_if);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({result_accept, out_valid, out_data, out_keep, out_last, fifo_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: acc=%b vld=%b data=%h keep=%h last=%b cnt=%0d, required all zero",
               result_accept, out_valid, out_data, out_keep, out_last, fifo_count);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (result_accept !== 1'b1 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: acc=%b cnt=%0d, required acc=1 cnt=0", result_accept, fifo_count);
    end
    @(negedge clk_if);
  endtask

  task automatic test_stream16();
    word_t g, e;
    for (int c = 0; c < 22; c++) begin
      step(c < 16, 16'(c + 1), c == 15, 1'b1);
      vectors++;
      if (s_acc !== s_acc_x || s_vld !== s_vld_x || s_cnt != s_cnt_x) begin
        miscompares++;
        $display("FAIL stream16 cycle %0d: acc/vld/cnt=%b/%b/%0d, required %b/%b/%0d",
                 c, s_acc, s_vld, s_cnt, s_acc_x, s_vld_x, s_cnt_x);
      end
    end
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++;
      $display("FAIL stream16 word_count: got %0d, required 2", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL stream16 word: got %h/%h/%b, required %h/%h/%b",
                 g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_partial_flush();
    word_t g, e;
    for (int c = 0; c < 10; c++) begin
      step(c < 3, 16'(16'hA1 + c), c == 5, 1'b1);
      vectors++;
      if (s_acc !== s_acc_x || s_vld !== s_vld_x || s_cnt != s_cnt_x) begin
        miscompares++;
        $display("FAIL partial cycle %0d: acc/vld/cnt=%b/%b/%0d, required %b/%b/%0d",
                 c, s_acc, s_vld, s_cnt, s_acc_x, s_vld_x, s_cnt_x);
      end
    end
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL partial word_count: got %0d, required 1", got_q.size());
    end else if (got_q[0].keep !== 8'h07 || got_q[0].last !== 1'b1) begin
      miscompares++;
      $display("FAIL partial keep_last: got %h/%b, required 07/1", got_q[0].keep, got_q[0].last);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL partial word: got %h/%h/%b, required %h/%h/%b",
                 g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    word_t g, e;
    int    sent = 0;
    for (int c = 0; c < 80; c++) begin
      step(sent < 40, 16'(16'h0100 + sent), 1'b0, c >= 50);
      if (sent < 40 && s_acc_x) sent++;
      vectors++;
      if (s_acc !== s_acc_x || s_vld !== s_vld_x || s_cnt != s_cnt_x) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: acc/vld/cnt=%b/%b/%0d, required %b/%b/%0d",
                 c, s_acc, s_vld, s_cnt, s_acc_x, s_vld_x, s_cnt_x);
      end
      if (c == 49) begin
        vectors++;
        if (s_cnt != 4 || s_acc !== 1'b0) begin
          miscompares++;
          $display("FAIL backpressure saturate: cnt=%0d acc=%b, required cnt=4 acc=0", s_cnt, s_acc);
        end
      end
    end
    vectors++;
    if (got_q.size() != 5) begin
      miscompares++;
      $display("FAIL backpressure word_count: got %0d, required 5", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL backpressure word: got %h/%h/%b, required %h/%h/%b",
                 g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_empty_flush();
    word_t g, e;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 16'h0, c == 0, 1'b1);
      vectors++;
      if (s_acc !== s_acc_x || s_vld !== s_vld_x || s_cnt != s_cnt_x) begin
        miscompares++;
        $display("FAIL empty_flush cycle %0d: acc/vld/cnt=%b/%b/%0d, required %b/%b/%0d",
                 c, s_acc, s_vld, s_cnt, s_acc_x, s_vld_x, s_cnt_x);
      end
    end
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL empty_flush word_count: got %0d, required 1", got_q.size());
    end else if (got_q[0] !== word_t'({128'h0, 8'h00, 1'b1})) begin
      miscompares++;
      $display("FAIL empty_flush word: got %h/%h/%b, required 0/00/1",
               got_q[0].data, got_q[0].keep, got_q[0].last);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL empty_flush model_word: got %h/%h/%b, required %h/%h/%b",
                 g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_flush_full();
    word_t g, e;
    for (int c = 0; c < 55; c++) begin
      step(c < 37, 16'(16'h0200 + c), c == 37, (c == 41) || (c >= 44));
      vectors++;
      if (s_acc !== s_acc_x || s_vld !== s_vld_x || s_cnt != s_cnt_x) begin
        miscompares++;
        $display("FAIL flush_full cycle %0d: acc/vld/cnt=%b/%b/%0d, required %b/%b/%0d",
                 c, s_acc, s_vld, s_cnt, s_acc_x, s_vld_x, s_cnt_x);
      end
      if (c == 40) begin
        vectors++;
        if (s_acc !== 1'b0 || s_cnt != 4) begin
          miscompares++;
          $display("FAIL flush_full blocked: acc=%b cnt=%0d, required acc=0 cnt=4", s_acc, s_cnt);
        end
      end
    end
    vectors++;
    if (got_q.size() != 5) begin
      miscompares++;
      $display("FAIL flush_full word_count: got %0d, required 5", got_q.size());
    end else if (got_q[4].keep !== 8'h1F || got_q[4].last !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_full closing: got %h/%b, required 1F/1", got_q[4].keep, got_q[4].last);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL flush_full word: got %h/%h/%b, required %h/%h/%b",
                 g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    word_t g, e;
    for (int c = 0; c < 21; c++) begin
      step(1'b1, 16'(16'h0300 + c), 1'b0, 1'b0);
    end
    vectors++;
    if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid preload: cnt=%0d vld=%b, required cnt=2 vld=1", fifo_count, out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({result_accept, out_valid, out_data, out_keep, out_last, fifo_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid values: acc=%b vld=%b data=%h keep=%h last=%b cnt=%0d, required all zero",
               result_accept, out_valid, out_data, out_keep, out_last, fifo_count);
    end
    model_reset();
    @(negedge clk_if);
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step(c < 8, 16'(16'h0400 + c), 1'b0, 1'b1);
      vectors++;
      if (s_acc !== s_acc_x || s_vld !== s_vld_x || s_cnt != s_cnt_x) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: acc/vld/cnt=%b/%b/%0d, required %b/%b/%0d",
                 c, s_acc, s_vld, s_cnt, s_acc_x, s_vld_x, s_cnt_x);
      end
    end
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL reset_mid word_count: got %0d, required 1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset_mid word: got %h/%h/%b, required %h/%h/%b",
                 g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    result_valid = 1'b0;
    result_data  = '0;
    result_flush = 1'b0;
    out_ready    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_if);
    test_reset();
    test_stream16();
    test_partial_flush();
    test_backpressure();
    test_empty_flush();
    test_flush_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
